// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and default bus widths
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating wait-state counter with expiry flag
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT means the transfer waits on PREADY forever
  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready request to APB SETUP/ACCESS requester
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Psel,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA
);

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timer_clear, timer_en, timer_expired;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESETn),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        timer_clear = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else if (timer_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Select/enable decode straight from state so reset drops them immediately
  assign req_ready = (state_q == IDLE);
  assign Psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master
module tb_apb_master;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              PCLK = 1'b0;
  logic              rst  = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              Psel, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  int                acc_cnt = 0;
  int                slave_waits = 0;
  logic [DATA_W-1:0] slave_rdata = '0;
  logic              pready_force = 1'b0;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                at;
  } rsp_t;
  rsp_t sb[$];

  apb_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESETn(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Psel(Psel), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: ready after slave_waits low ACCESS cycles; negative means never
  always @(posedge PCLK or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else if (Psel && PENABLE) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    PREADY = pready_force;
    if (Psel && PENABLE && (slave_waits >= 0) && (acc_cnt >= slave_waits)) PREADY = 1'b1;
  end
  assign PRDATA = slave_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge PCLK) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc, e.at);
        chk("rsp_req_ready", {31'd0, req_ready}, 32'd1);
      end
    end
  end

  // waits < 0 leaves PREADY low so the timeout fires
  task automatic run_xfer(input logic w, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int waits,
                          input logic [DATA_W-1:0] rdata, input bit noise);
    int   n, acc;
    rsp_t e;
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wdata;
    slave_waits = waits; slave_rdata = rdata;
    @(negedge PCLK);
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    n   = cyc;
    acc = (waits < 0) ? TIMEOUT : waits + 1;
    e.err   = (waits < 0);
    e.rdata = (w || waits < 0) ? '0 : rdata;
    e.at    = n + 2 + acc;
    sb.push_back(e);
    @(posedge PCLK); #1;
    req_valid = noise;
    if (noise) req_addr = ~addr;
    @(negedge PCLK);
    chk("setup_psel", {31'd0, Psel}, 32'd1);
    chk("setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("setup_ready", {31'd0, req_ready}, 32'd0);
    chk("setup_paddr", {27'd0, PADDR}, {27'd0, addr});
    chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, w});
    chk("setup_pwdata", PWDATA, wdata);
    for (int i = 0; i < acc; i++) begin
      @(posedge PCLK); #1;
      if (noise) begin
        req_valid = ~req_valid;
        req_addr  = req_addr + 5'd1;
      end
      @(negedge PCLK);
      chk("access_psel", {31'd0, Psel}, 32'd1);
      chk("access_penable", {31'd0, PENABLE}, 32'd1);
      chk("access_paddr", {27'd0, PADDR}, {27'd0, addr});
      chk("access_pwdata", PWDATA, wdata);
    end
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("done_psel", {31'd0, Psel}, 32'd0);
    chk("done_penable", {31'd0, PENABLE}, 32'd0);
    chk("done_paddr_hold", {27'd0, PADDR}, {27'd0, addr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected end before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       exp_psel [1:6];
    logic       exp_pen  [1:6];
    logic [4:0] exp_addr [1:6];
    int         n;
    rsp_t       e;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", {31'd0, Psel}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rst_paddr", {27'd0, PADDR}, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge PCLK); #1;
    rst = 1'b0;

    run_xfer(1'b1, 5'h03, 32'hDEADBEEF, 0, 32'h0BAD0BAD, 1'b0);
    run_xfer(1'b0, 5'h03, 32'h00000000, 2, 32'hDEADBEEF, 1'b0);
    repeat (3) @(negedge PCLK);
    chk("rdata_hold", rsp_rdata, 32'hDEADBEEF);
    run_xfer(1'b0, 5'h07, 32'h00000000, -1, 32'h5555AAAA, 1'b0);

    // Back-to-back: req_valid held across the first response
    exp_psel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_pen  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_addr = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2};
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd1; req_wdata = 32'hAAAA0001;
    slave_waits = 0;
    @(negedge PCLK);
    n = cyc;
    e.err = 1'b0; e.rdata = '0; e.at = n + 3; sb.push_back(e);
    e.at = n + 6; sb.push_back(e);
    @(posedge PCLK); #1;
    req_addr = 5'd2; req_wdata = 32'hBBBB0002;
    for (int k = 1; k <= 6; k++) begin
      @(negedge PCLK);
      chk("b2b_psel", {31'd0, Psel}, {31'd0, exp_psel[k]});
      chk("b2b_penable", {31'd0, PENABLE}, {31'd0, exp_pen[k]});
      chk("b2b_paddr", {27'd0, PADDR}, {27'd0, exp_addr[k]});
      if (k == 4) chk("b2b_pwdata", PWDATA, 32'hBBBB0002);
      if (k == 3) begin
        @(posedge PCLK); #1;
        req_valid = 1'b0;
      end
    end

    // Reset during ACCESS of a read: no response may follow
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h09; slave_waits = -1;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #2;
    chk("pre_rst_penable", {31'd0, PENABLE}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_psel", {31'd0, Psel}, 32'd0);
    chk("async_rst_penable", {31'd0, PENABLE}, 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    rst = 1'b0;
    @(negedge PCLK);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    run_xfer(1'b0, 5'h09, 32'h00000000, 0, 32'h12345678, 1'b0);

    run_xfer(1'b1, 5'h0A, 32'hCAFEF00D, 1, 32'h0, 1'b1);

    // PREADY in IDLE must not start or complete anything
    @(posedge PCLK); #1;
    pready_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("idle_pready_psel", {31'd0, Psel}, 32'd0);
      chk("idle_pready_paddr", {27'd0, PADDR}, 32'h0A);
    end
    @(posedge PCLK); #1;
    pready_force = 1'b0;
    repeat (3) @(negedge PCLK);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester stage sitting directly upstream of the GPIO APB slave.
- Converts a simple valid/ready request from the core/bus side into a compliant APB SETUP → ACCESS sequence.
- Drives PSEL/PENABLE/PWRITE/PADDR/PWDATA and consumes PREADY/PRDATA.
- Returns a one-cycle response pulse with read data or error; aborts transfers that exceed a wait-state timeout.

Parameters:
- ADDR_W, 5, width of PADDR and req_addr.
- DATA_W, 32, width of PWDATA, PRDATA, req_wdata, rsp_rdata.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
- PCLK  input  1  system clock, all logic on rising edge.
- PRESETn  input  1  asynchronous, active-high reset (despite the name; 1 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data; 0 for writes or errors.
- rsp_err  output  1  1 = timeout abort, qualified by rsp_valid.
- Psel  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PREADY  input  1  slave ready (may be combinational from Psel&PENABLE).
- PRDATA  input  DATA_W  slave read data, sampled when PREADY=1 in ACCESS.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - Psel, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, wait counter all 0.
  - A transfer in flight when reset asserts is dropped; no response is issued.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready = 1; Psel = PENABLE = 0.
  - PADDR, PWDATA, PWRITE hold their last values.
  - On req_valid & req_ready, register req_addr/req_wdata/req_write into PADDR/PWDATA/PWRITE; next state = SETUP.
- SETUP (exactly 1 cycle): Psel = 1, PENABLE = 0, req_ready = 0; next state = ACCESS; wait counter cleared.
- ACCESS: Psel = 1, PENABLE = 1, req_ready = 0.
  - If PREADY = 1:
    - capture PRDATA into rsp_rdata for reads (0 for writes), rsp_err = 0.
    - rsp_valid = 1 on the next cycle; next state = IDLE.
  - Else if TIMEOUT ≠ 0 and the counter equals TIMEOUT−1:
    - abort; next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; next state = IDLE.
  - Else increment the counter and stay in ACCESS.
- PADDR, PWDATA, PWRITE are stable from SETUP through the final ACCESS cycle.
- Latency: acceptance in cycle N → SETUP N+1 → ACCESS N+2 → rsp_valid N+3 with zero wait states. Each PREADY-low cycle adds 1.
- Response handling:
  - rsp_valid is a single-cycle pulse with no backpressure.
  - rsp_rdata and rsp_err hold their values until the next response.
  - A new request may be accepted in the same cycle rsp_valid is high, giving a back-to-back period of 3 cycles.
- Ignored inputs:
  - req_valid outside IDLE is ignored; the requester must hold it until req_ready.
  - PREADY outside ACCESS is ignored.
- Counter: width $clog2(TIMEOUT+1), minimum 1; saturates, never wraps.

Decomposition:
- Package apb_pkg:
  - typedef apb_state_t {IDLE, SETUP, ACCESS};
  - localparams APB_ADDR_W = 5, APB_DATA_W = 32;
  - shared by this block and the GPIO slave.
- Sub-module apb_wait_timer: clear / enable / expired counter parameterised by TIMEOUT.
- FSM and datapath registers stay in apb_master.

Test Plan:
- Zero-wait write: req write addr 5'h03, wdata 32'hDEADBEEF; PREADY = 1 during ACCESS → Psel high cycles N+1..N+2, PENABLE high N+2 only, PADDR = 3 stable; rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read with 2 wait states: read addr 5'h03; PREADY low 2 ACCESS cycles, then high with PRDATA = 32'hDEADBEEF → rsp_valid at N+5, rsp_rdata = 32'hDEADBEEF.
- Timeout: TIMEOUT = 4, PREADY tied 0 → exactly 4 ACCESS cycles, then Psel/PENABLE drop; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; req_ready = 1 that cycle.
- Back-to-back: req_valid held high with writes to addr 1 then 2 → second SETUP begins the cycle after the first rsp_valid; PADDR changes only at acceptance; period 3 cycles.
- Reset mid-ACCESS: assert PRESETn during ACCESS of a read → Psel/PENABLE go 0 asynchronously, no rsp_valid; after release req_ready = 1 and a new read completes normally.
- Ignored inputs: toggle req_valid and change req_addr during SETUP/ACCESS, and pulse PREADY in IDLE → PADDR unchanged, no spurious rsp_valid.
